moto_ramp_seq: RTL and testbench

//  Soft-start / soft-stop sequencer for the DC motor PWM stage. Converts level commands
//  (run, direction, 2-bit speed) into a ramped duty word, PWM enable and latched direction.

---
 rtl/moto_ramp_seq.sv | 171 +++++++++++++++++
 tb/tb_moto_ramp_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moto_ramp_seq.sv
// Soft-start/stop motor sequencer: ramps the PWM duty toward the commanded speed and inserts dead time before reversal.
// Latency: all outputs registered, a command change acts on the next edge; no backpressure, commands are sampled levels.
module moto_ramp_seq #(
    parameter int                DUTY_W   = 8,
    parameter int                STEP     = 16,
    parameter int                STEP_DIV = 1000,
    parameter int                DEAD_CYC = 5000,
    parameter logic [DUTY_W-1:0] SPD0     = DUTY_W'(0),
    parameter logic [DUTY_W-1:0] SPD1     = DUTY_W'(64),
    parameter logic [DUTY_W-1:0] SPD2     = DUTY_W'(128),
    parameter logic [DUTY_W-1:0] SPD3     = DUTY_W'(255)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_run,
    input  logic              cmd_dir,
    input  logic [1:0]        cmd_speed,
    input  logic              estop,
    output logic              pwm_en,
    output logic [DUTY_W-1:0] pwm_duty,
    output logic              moto_dir,
    output logic              busy,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAMP = 3'd1,
        ST_RUN  = 3'd2,
        ST_DEAD = 3'd3
    } state_t;

    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int SUM_W  = DUTY_W + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
    localparam logic [SUM_W-1:0]  STEP_X    = SUM_W'(STEP);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);

    state_t              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                dir_q, dir_d;
    logic                pwm_en_q;
    logic                busy_q;

    logic [DUTY_W-1:0]   spd_sel;
    logic [DUTY_W-1:0]   tgt;
    logic [DUTY_W-1:0]   eff;
    logic [SUM_W-1:0]    duty_x;
    logic [SUM_W-1:0]    eff_x;
    logic [SUM_W-1:0]    up_sum;
    logic [SUM_W-1:0]    dn_floor;
    logic [DUTY_W-1:0]   duty_up;
    logic [DUTY_W-1:0]   duty_dn;

    always_comb begin
        spd_sel = SPD0;
        unique case (cmd_speed)
            2'd0: spd_sel = SPD0;
            2'd1: spd_sel = SPD1;
            2'd2: spd_sel = SPD2;
            2'd3: spd_sel = SPD3;
        endcase
    end

    // A direction request that differs from the latched direction means "spin down first".
    assign tgt = cmd_run ? spd_sel : '0;
    assign eff = (cmd_dir == dir_q) ? tgt : '0;

    assign duty_x   = {1'b0, duty_q};
    assign eff_x    = {1'b0, eff};
    assign up_sum   = duty_x + STEP_X;
    assign duty_up  = (up_sum >= eff_x) ? eff : up_sum[DUTY_W-1:0];
    // Compare against eff+STEP rather than subtracting first, so the down step cannot underflow.
    assign dn_floor = eff_x + STEP_X;
    assign duty_dn  = (duty_x <= dn_floor) ? eff : (duty_q - STEP_D);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tick_d  = tick_q;
        dead_d  = dead_q;
        dir_d   = dir_q;

        if (estop && (state_q != ST_DEAD)) begin
            state_d = ST_DEAD;
            duty_d  = '0;
            dead_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (tgt != '0) begin
                        dir_d   = cmd_dir;
                        tick_d  = '0;
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (duty_q == eff) begin
                        if (eff != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DEAD;
                            dead_d  = '0;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        duty_d = (duty_q < eff) ? duty_up : duty_dn;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_RUN: begin
                    if (eff != duty_q) begin
                        state_d = ST_RAMP;
                        tick_d  = '0;
                    end
                end
                ST_DEAD: begin
                    // Held estop pins the counter, so the full dead time starts at release.
                    duty_d = '0;
                    if (estop) begin
                        dead_d = '0;
                    end else if (dead_q == DEAD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        dead_d = dead_q + DEAD_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            tick_q   <= '0;
            dead_q   <= '0;
            dir_q    <= 1'b0;
            pwm_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            tick_q   <= tick_d;
            dead_q   <= dead_d;
            dir_q    <= dir_d;
            pwm_en_q <= (state_d == ST_RAMP) || (state_d == ST_RUN);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign pwm_en   = pwm_en_q;
    assign pwm_duty = duty_q;
    assign moto_dir = dir_q;
    assign busy     = busy_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_moto_ramp_seq.sv
// Bench for moto_ramp_seq: directed scenarios plus random commands, checked against an integer reference model.
// Model steps once per clock from the same command levels the design samples on that edge.
module tb_moto_ramp_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cmd_run;
    logic       cmd_dir;
    logic [1:0] cmd_speed;
    logic       estop;
    logic       pwm_en;
    logic [7:0] pwm_duty;
    logic       moto_dir;
    logic       busy;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    int m_state, m_duty, m_tick, m_dead, m_dir;
    int spd_tab [4] = '{0, 64, 128, 255};

    wire [13:0] act = {state_o, pwm_duty, pwm_en, moto_dir, busy};

    always #5 sys_clk = ~sys_clk;

    moto_ramp_seq #(
        .DUTY_W(8), .STEP(16), .STEP_DIV(4), .DEAD_CYC(8),
        .SPD0(8'd0), .SPD1(8'd64), .SPD2(8'd128), .SPD3(8'd255)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_run(cmd_run), .cmd_dir(cmd_dir),
        .cmd_speed(cmd_speed), .estop(estop), .pwm_en(pwm_en), .pwm_duty(pwm_duty),
        .moto_dir(moto_dir), .busy(busy), .state_o(state_o)
    );

    task automatic model_reset();
        m_state = 0; m_duty = 0; m_tick = 0; m_dead = 0; m_dir = 0;
    endtask

    task automatic model_step();
        int tgt, eff;
        if (!sys_rst_n) begin
            model_reset();
            return;
        end
        tgt = cmd_run ? spd_tab[cmd_speed] : 0;
        eff = (int'(cmd_dir) == m_dir) ? tgt : 0;
        if (estop && m_state != 3) begin
            m_state = 3; m_duty = 0; m_dead = 0;
            return;
        end
        case (m_state)
            0: if (tgt != 0) begin m_dir = int'(cmd_dir); m_tick = 0; m_state = 1; end
            1: begin
                if (m_duty == eff) begin
                    m_state = (eff != 0) ? 2 : 3;
                    m_dead  = 0;
                end else if (m_tick == 3) begin
                    m_tick = 0;
                    if (m_duty < eff) m_duty = (m_duty + 16 > eff) ? eff : m_duty + 16;
                    else              m_duty = (m_duty - 16 < eff) ? eff : m_duty - 16;
                end else begin
                    m_tick++;
                end
            end
            2: if (eff != m_duty) begin m_state = 1; m_tick = 0; end
            default: begin
                if (estop)            m_dead = 0;
                else if (m_dead == 7) m_state = 0;
                else                  m_dead++;
            end
        endcase
    endtask

    function automatic logic [13:0] exp_vec();
        logic [13:0] v;
        v = {3'(m_state), 8'(m_duty), (m_state == 1 || m_state == 2), 1'(m_dir), (m_state != 0)};
        return v;
    endfunction

    task automatic cyc();
        model_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (act !== 14'h0) begin errors++; $display("FAIL reset_vals got %h want %h", act, 14'h0); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc();
        checks++;
        if (act !== exp_vec()) begin errors++; $display("FAIL reset_idle got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_start();
        cmd_run = 1'b1; cmd_speed = 2'd1; cmd_dir = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL start_model cyc%0d got %h want %h", i, act, exp_vec()); end
            if (i == 1) begin
                checks++;
                if (state_o !== 3'd1 || pwm_en !== 1'b1 || moto_dir !== 1'b0) begin
                    errors++; $display("FAIL start_enter got st=%0d en=%b dir=%b want st=1 en=1 dir=0", state_o, pwm_en, moto_dir);
                end
            end
            if (i == 5 || i == 9 || i == 13 || i == 17) begin
                checks++;
                if (pwm_duty !== 8'((i - 1) / 4 * 16)) begin
                    errors++; $display("FAIL start_duty cyc%0d got %0d want %0d", i, pwm_duty, (i - 1) / 4 * 16);
                end
            end
            if (i == 18) begin
                checks++;
                if (state_o !== 3'd2 || pwm_duty !== 8'd64) begin
                    errors++; $display("FAIL start_run got st=%0d duty=%0d want st=2 duty=64", state_o, pwm_duty);
                end
            end
        end
    endtask

    task automatic test_clamp();
        int prev, seen_top, seen_15, dead_cnt, done;
        cmd_speed = 2'd3; prev = 64; seen_top = 0; done = 0;
        for (int i = 0; i < 100 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL clamp_up got %h want %h", act, exp_vec()); end
            if (prev == 240 && pwm_duty == 8'd255) seen_top = 1;
            prev = int'(pwm_duty);
            if (state_o == 3'd2 && pwm_duty == 8'd255) done = 1;
        end
        checks++;
        if (seen_top != 1 || done != 1) begin errors++; $display("FAIL clamp_top got seen=%0d done=%0d want 1 1", seen_top, done); end
        cmd_speed = 2'd0; seen_15 = 0; dead_cnt = 0; done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL clamp_down got %h want %h", act, exp_vec()); end
            if (pwm_duty == 8'd15) seen_15 = 1;
            if (state_o == 3'd3) dead_cnt++;
            if (state_o == 3'd0 && dead_cnt > 0) done = 1;
        end
        checks++;
        if (dead_cnt != 8 || seen_15 != 1 || done != 1) begin
            errors++; $display("FAIL clamp_dead got dead=%0d s15=%0d done=%0d want 8 1 1", dead_cnt, seen_15, done);
        end
    endtask

    task automatic test_reverse();
        int done, dead_cnt, bad_toggle;
        logic prev_en, prev_dir;
        cmd_speed = 2'd2; done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL rev_up got %h want %h", act, exp_vec()); end
            if (state_o == 3'd2 && pwm_duty == 8'd128) done = 1;
        end
        cmd_dir = 1'b1; done = 0; dead_cnt = 0; bad_toggle = 0;
        prev_en = pwm_en; prev_dir = moto_dir;
        for (int i = 0; i < 300 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL rev_model got %h want %h", act, exp_vec()); end
            if (prev_en && pwm_en && moto_dir != prev_dir) bad_toggle++;
            if (state_o == 3'd3) dead_cnt++;
            prev_en = pwm_en; prev_dir = moto_dir;
            if (state_o == 3'd2 && moto_dir == 1'b1) done = 1;
        end
        checks++;
        if (done != 1 || dead_cnt != 8 || bad_toggle != 0 || pwm_duty !== 8'd128) begin
            errors++; $display("FAIL rev_result got done=%0d dead=%0d tog=%0d duty=%0d want 1 8 0 128", done, dead_cnt, bad_toggle, pwm_duty);
        end
    endtask

    task automatic test_estop();
        int done, cnt;
        estop = 1'b1;
        cyc();
        estop = 1'b0;
        checks++;
        if (state_o !== 3'd3 || pwm_en !== 1'b0 || pwm_duty !== 8'd0 || act !== exp_vec()) begin
            errors++; $display("FAIL estop_pulse got %h want %h", act, exp_vec());
        end
        done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL estop_recover got %h want %h", act, exp_vec()); end
            if (state_o == 3'd2) done = 1;
        end
        estop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (state_o !== 3'd3 || act !== exp_vec()) begin errors++; $display("FAIL estop_held got %h want %h", act, exp_vec()); end
        end
        estop = 1'b0; cnt = 0; done = 0;
        for (int i = 0; i < 50 && done == 0; i++) begin
            cyc();
            cnt++;
            if (state_o != 3'd3) done = 1;
        end
        checks++;
        if (cnt != 8 || done != 1) begin errors++; $display("FAIL estop_release got %0d cycles want 8", cnt); end
    endtask

    task automatic test_retarget();
        int done, max_duty;
        cmd_run = 1'b0; done = 0;
        for (int i = 0; i < 300 && done == 0; i++) begin
            cyc();
            if (state_o == 3'd0) done = 1;
        end
        checks++;
        if (act !== exp_vec() || done != 1) begin errors++; $display("FAIL retgt_idle got %h want %h", act, exp_vec()); end
        cmd_run = 1'b1; cmd_speed = 2'd2; done = 0;
        for (int i = 0; i < 100 && done == 0; i++) begin
            cyc();
            if (pwm_duty == 8'd48) done = 1;
        end
        cmd_speed = 2'd1; done = 0; max_duty = 0;
        for (int i = 0; i < 50 && done == 0; i++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL retgt_model got %h want %h", act, exp_vec()); end
            if (int'(pwm_duty) > max_duty) max_duty = int'(pwm_duty);
            if (state_o == 3'd2) done = 1;
        end
        checks++;
        if (done != 1 || max_duty != 64 || pwm_duty !== 8'd64) begin
            errors++; $display("FAIL retgt_result got done=%0d max=%0d duty=%0d want 1 64 64", done, max_duty, pwm_duty);
        end
    endtask

    task automatic test_reset_mid();
        cmd_speed = 2'd3;
        for (int i = 0; i < 6; i++) cyc();
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("FAIL rstmid_pre got st=%0d want 1", state_o); end
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act !== 14'h0) begin errors++; $display("FAIL rstmid_async got %h want %h", act, 14'h0); end
        cmd_run = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc();
        checks++;
        if (act !== exp_vec()) begin errors++; $display("FAIL rstmid_after got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_random();
        int hold, est;
        hold = 0; est = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                hold      = int'($urandom_range(1, 60));
                cmd_run   = ($urandom_range(0, 3) != 0);
                cmd_speed = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) cmd_dir = ~cmd_dir;
            end else begin
                hold--;
            end
            if (est == 0 && $urandom_range(0, 149) == 0) est = int'($urandom_range(1, 25));
            estop = (est != 0);
            if (est > 0) est--;
            cyc();
            checks++;
            if (act !== exp_vec()) begin errors++; $display("FAIL random cyc%0d got %h want %h", i, act, exp_vec()); end
        end
    endtask

    initial begin
        sys_rst_n = 1'b0; cmd_run = 1'b0; cmd_dir = 1'b0; cmd_speed = 2'd0; estop = 1'b0;
        model_reset();
        test_reset();
        test_start();
        test_clamp();
        test_reverse();
        test_estop();
        test_retarget();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
